// File: rtl/conn_tuple_reader.sv
// -----------------------------------------------------------------------------
// conn_tuple_reader
//
// Read side of the TOE connection table. Takes a connection ID from the TX
// path and fetches its 145-bit entry from the table RAM. It then returns the
// stored MAC/IP/port tuple to the header builder, or reports an invalid or
// out-of-range ID. While the insert/delete searcher owns the RAM, the reader
// waits and does not issue an address. Only one request is outstanding at a
// time.
//
// Entry layout (ENTRY_W = 145, fixed):
//   [144:121] mac_src  [120:97] mac_dst  [96:65] ip_src  [64:33] ip_dst
//   [32:17]   port_src [16:1]   port_dst [0]     valid
//
// Ports:
//   cr_clk, cr_rst            clock, synchronous active-high reset
//   cr_req_valid/ready        request handshake; ready is high only in IDLE
//   cr_id_in                  connection ID to look up
//   cr_tbl_busy               searcher owns the RAM this cycle
//   cr_ram_addr/rden/q        RAM read port (q arrives RD_LAT clocks after rden)
//   cr_rsp_valid/ready        response handshake
//   cr_mac_*/ip_*/port_*      returned tuple fields
//   cr_id_out                 ID of the current response
//   cr_error                  0x00 ok, 0x01 entry invalid, 0x02 ID out of range
// -----------------------------------------------------------------------------
module conn_tuple_reader #(
    parameter int DEPTH   = 128,
    parameter int RD_LAT  = 1,
    parameter int ENTRY_W = 145
) (
    input  logic               cr_clk,
    input  logic               cr_rst,
    input  logic               cr_req_valid,
    output logic               cr_req_ready,
    input  logic [7:0]         cr_id_in,
    input  logic               cr_tbl_busy,
    output logic [7:0]         cr_ram_addr,
    output logic               cr_ram_rden,
    input  logic [ENTRY_W-1:0] cr_ram_q,
    output logic               cr_rsp_valid,
    input  logic               cr_rsp_ready,
    output logic [23:0]        cr_mac_src,
    output logic [23:0]        cr_mac_dst,
    output logic [31:0]        cr_ip_src,
    output logic [31:0]        cr_ip_dst,
    output logic [15:0]        cr_port_src,
    output logic [15:0]        cr_port_dst,
    output logic [7:0]         cr_id_out,
    output logic [7:0]         cr_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);
    // The counter runs from RD_LAT-1 down to 0 in WAIT, so the capture edge
    // lands exactly RD_LAT clocks after the rden cycle.
    localparam logic [1:0] CNT_LOAD  = 2'(RD_LAT - 1);

    localparam logic [7:0] ERR_OK      = 8'h00;
    localparam logic [7:0] ERR_INVALID = 8'h01;
    localparam logic [7:0] ERR_RANGE   = 8'h02;

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     id_q;
    logic [7:0]     addr_q;
    logic [1:0]     cnt_q;
    logic [143:0]   tuple_q;
    logic [7:0]     err_q;
    logic [7:0]     id_out_q;

    logic           req_ready_s;
    logic           rsp_valid_s;
    logic           rden_s;
    logic           accept_s;
    logic           oor_s;

    // Tuple part of an entry; an invalid entry yields an all-zero tuple.
    function automatic logic [143:0] entry_tuple(input logic [ENTRY_W-1:0] entry);
        logic [143:0] t;
        if (entry[0]) begin
            t = entry[144:1];
        end else begin
            t = 144'd0;
        end
        return t;
    endfunction

    // Error code for a fetched (in-range) entry.
    function automatic logic [7:0] entry_error(input logic [ENTRY_W-1:0] entry);
        logic [7:0] e;
        if (entry[0]) begin
            e = ERR_OK;
        end else begin
            e = ERR_INVALID;
        end
        return e;
    endfunction

    assign accept_s = cr_req_valid && req_ready_s;
    assign oor_s    = ({1'b0, cr_id_in} >= DEPTH_LIM);

    // FSM state register.
    always_ff @(posedge cr_clk) begin
        if (cr_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (oor_s) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rden_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (cr_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs. The read strobe must react to busy in the same cycle, and
    // it is held off while reset is asserted so a stale ISSUE never reaches
    // the RAM.
    always_comb begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
        rden_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = 1'b1;
            end
            ST_ISSUE: begin
                if (!cr_tbl_busy && !cr_rst) begin
                    rden_s = 1'b1;
                end else begin
                    rden_s = 1'b0;
                end
            end
            ST_WAIT: begin
                rden_s = 1'b0;
            end
            ST_RESP: begin
                rsp_valid_s = 1'b1;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Datapath: latch the ID, track the issued address, count the read
    // latency, and capture or synthesize the response.
    always_ff @(posedge cr_clk) begin
        if (cr_rst) begin
            id_q     <= 8'd0;
            addr_q   <= 8'd0;
            cnt_q    <= 2'd0;
            tuple_q  <= 144'd0;
            err_q    <= 8'd0;
            id_out_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        id_q <= cr_id_in;
                        // Out-of-range IDs skip the RAM entirely.
                        if (oor_s) begin
                            tuple_q  <= 144'd0;
                            err_q    <= ERR_RANGE;
                            id_out_q <= cr_id_in;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rden_s) begin
                        addr_q <= id_q;
                        cnt_q  <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        tuple_q  <= entry_tuple(cr_ram_q);
                        err_q    <= entry_error(cr_ram_q);
                        id_out_q <= id_q;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_RESP: begin
                    // The tuple and error hold after the handshake; only
                    // the ID is cleared.
                    if (cr_rsp_ready) begin
                        id_out_q <= 8'd0;
                    end
                end
                default: begin
                    id_q <= id_q;
                end
            endcase
        end
    end

    // The address shows the current ID on the strobe cycle and holds the
    // last issued address otherwise.
    assign cr_ram_addr  = rden_s ? id_q : addr_q;
    assign cr_ram_rden  = rden_s;
    assign cr_req_ready = req_ready_s;
    assign cr_rsp_valid = rsp_valid_s;

    assign cr_mac_src   = tuple_q[143:120];
    assign cr_mac_dst   = tuple_q[119:96];
    assign cr_ip_src    = tuple_q[95:64];
    assign cr_ip_dst    = tuple_q[63:32];
    assign cr_port_src  = tuple_q[31:16];
    assign cr_port_dst  = tuple_q[15:0];
    assign cr_id_out    = id_out_q;
    assign cr_error     = err_q;

endmodule

// File: tb/tb_conn_tuple_reader.sv
// -----------------------------------------------------------------------------
// tb_conn_tuple_reader
//
// Two readers are instantiated, one with RD_LAT=1 and one with RD_LAT=3. Each
// reader has its own delayed-read RAM model. The RAM model returns random
// junk on every cycle that is not a read slot, so a capture on the wrong edge
// gives wrong data. Expected responses are computed from a field-level table
// of entries.
// -----------------------------------------------------------------------------
module tb_conn_tuple_reader;

    typedef struct packed {
        logic [23:0] mac_src;
        logic [23:0] mac_dst;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] sport;
        logic [15:0] dport;
        logic        valid;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst        [2];
    logic         req_valid  [2];
    logic         req_ready  [2];
    logic [7:0]   id_in      [2];
    logic         busy       [2];
    logic [7:0]   addr       [2];
    logic         rden       [2];
    logic [144:0] ram_q      [2];
    logic         rsp_valid  [2];
    logic         rsp_ready  [2];
    logic [23:0]  mac_src    [2];
    logic [23:0]  mac_dst    [2];
    logic [31:0]  ip_src     [2];
    logic [31:0]  ip_dst     [2];
    logic [15:0]  port_src   [2];
    logic [15:0]  port_dst   [2];
    logic [7:0]   id_out     [2];
    logic [7:0]   err        [2];

    ent_t         ent  [256];
    logic [144:0] pipe [2][4];
    logic [7:0]   last_addr [2];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        conn_tuple_reader #(.DEPTH(128), .RD_LAT(LAT), .ENTRY_W(145)) u_dut (
            .cr_clk       (clk),
            .cr_rst       (rst[g]),
            .cr_req_valid (req_valid[g]),
            .cr_req_ready (req_ready[g]),
            .cr_id_in     (id_in[g]),
            .cr_tbl_busy  (busy[g]),
            .cr_ram_addr  (addr[g]),
            .cr_ram_rden  (rden[g]),
            .cr_ram_q     (ram_q[g]),
            .cr_rsp_valid (rsp_valid[g]),
            .cr_rsp_ready (rsp_ready[g]),
            .cr_mac_src   (mac_src[g]),
            .cr_mac_dst   (mac_dst[g]),
            .cr_ip_src    (ip_src[g]),
            .cr_ip_dst    (ip_dst[g]),
            .cr_port_src  (port_src[g]),
            .cr_port_dst  (port_dst[g]),
            .cr_id_out    (id_out[g]),
            .cr_error     (err[g])
        );

        // RAM model: data read on the rden cycle appears LAT cycles later;
        // every other slot carries junk.
        always @(posedge clk) begin
            if (rden[g]) begin
                pipe[g][0] <= ent[addr[g]];
            end else begin
                pipe[g][0] <= {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
            for (int i = 1; i < 4; i++) begin
                pipe[g][i] <= pipe[g][i-1];
            end
        end
        assign ram_q[g] = pipe[g][LAT-1];
    end

    task automatic check_eq(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [143:0] obs_tuple(input int k);
        return {mac_src[k], mac_dst[k], ip_src[k], ip_dst[k], port_src[k], port_dst[k]};
    endfunction

    // Expected response for an ID, computed from the entry table.
    task automatic model(input logic [7:0] id, output logic [143:0] et, output logic [7:0] ee);
        ent_t e;
        if (id >= 8'd128) begin
            et = '0;
            ee = 8'h02;
        end else begin
            e = ent[id];
            if (e.valid) begin
                et = {e.mac_src, e.mac_dst, e.ip_src, e.ip_dst, e.sport, e.dport};
                ee = 8'h00;
            end else begin
                et = '0;
                ee = 8'h01;
            end
        end
    endtask

    // Checks that every output has its reset value.
    task automatic check_idle_zero(input int k, input string tag);
        check_eq({tag, "_req_ready"}, req_ready[k], 1'b1);
        check_eq({tag, "_rsp_valid"}, rsp_valid[k], 1'b0);
        check_eq({tag, "_rden"}, rden[k], 1'b0);
        check_eq({tag, "_addr"}, addr[k], 8'h00);
        check_eq({tag, "_tuple"}, obs_tuple(k), 144'd0);
        check_eq({tag, "_id_out"}, id_out[k], 8'h00);
        check_eq({tag, "_error"}, err[k], 8'h00);
    endtask

    // One full transaction. The table is busy for nb cycles after accept,
    // and the response is held for 'hold' valid cycles before it is taken.
    task automatic do_req(input int k, input logic [7:0] id, input int nb, input int hold);
        int j, rden_j, rden_n, valid_j, nv, lat;
        logic done, oor;
        logic [143:0] et;
        logic [7:0] ee;
        lat = (k == 0) ? 1 : 3;
        oor = (id >= 8'd128);
        model(id, et, ee);
        @(posedge clk); #1;
        req_valid[k] = 1'b1; id_in[k] = id; rsp_ready[k] = 1'b0; busy[k] = 1'b0;
        @(negedge clk);
        check_eq("req_ready_idle", req_ready[k], 1'b1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0; id_in[k] = 8'($urandom);
        j = 1; rden_j = 0; rden_n = 0; valid_j = 0; nv = 0; done = 1'b0;
        while (!done && j < 80) begin
            busy[k] = (j <= nb) || (rden_n > 0 && $urandom_range(0, 1) == 1);
            rsp_ready[k] = (nv >= hold);
            @(negedge clk);
            check_eq("rden_while_busy", rden[k] & busy[k], 1'b0);
            if (rden[k]) begin
                rden_n++;
                if (rden_n == 1) rden_j = j;
                check_eq("rden_addr", addr[k], id);
                last_addr[k] = id;
            end else begin
                check_eq("addr_hold", addr[k], last_addr[k]);
            end
            if (rsp_valid[k]) begin
                if (nv == 0) valid_j = j;
                nv++;
                check_eq("rsp_tuple", obs_tuple(k), et);
                check_eq("rsp_error", err[k], ee);
                check_eq("rsp_id", id_out[k], id);
                check_eq("req_ready_in_resp", req_ready[k], 1'b0);
                if (rsp_ready[k]) done = 1'b1;
            end else begin
                check_eq("req_ready_busy", req_ready[k], 1'b0);
            end
            j++;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        check_eq("rsp_timeout", done, 1'b1);
        check_eq("rden_count", rden_n, oor ? 0 : 1);
        check_eq("rsp_latency", valid_j, oor ? 1 : nb + lat + 2);
        if (!oor) check_eq("rden_to_rsp", valid_j - rden_j, lat + 1);
        @(posedge clk); #1;
        busy[k] = 1'b0; rsp_ready[k] = 1'b0;
        @(negedge clk);
        check_eq("post_rsp_valid", rsp_valid[k], 1'b0);
        check_eq("post_id_out", id_out[k], 8'h00);
        check_eq("post_req_ready", req_ready[k], 1'b1);
        check_eq("post_tuple_hold", obs_tuple(k), et);
    endtask

    // Reset pulsed while the read is outstanding; the late RAM data must be
    // ignored.
    task automatic rst_mid(input int k, input logic [7:0] id);
        @(posedge clk); #1;
        req_valid[k] = 1'b1; id_in[k] = id; busy[k] = 1'b0; rsp_ready[k] = 1'b1;
        @(negedge clk);
        check_eq("rst_req_ready", req_ready[k], 1'b1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        @(negedge clk);
        check_eq("rst_rden", rden[k], 1'b1);
        @(posedge clk); #1;
        rst[k] = 1'b1;
        @(posedge clk); #1;
        rst[k] = 1'b0;
        @(negedge clk);
        check_idle_zero(k, "rst_mid");
        last_addr[k] = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("rst_late_q_valid", rsp_valid[k], 1'b0);
            check_eq("rst_late_q_tuple", obs_tuple(k), 144'd0);
        end
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ent[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
        ent[5] = '{mac_src: 24'hAABBCC, mac_dst: 24'h112233, ip_src: 32'h0A000001,
                   ip_dst: 32'h0A000002, sport: 16'h1F90, dport: 16'h0050, valid: 1'b1};
        ent[7].valid   = 1'b0;
        ent[3].valid   = 1'b1;
        ent[4].valid   = 1'b1;
        ent[127].valid = 1'b1;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; id_in[k] = 8'h00;
            busy[k] = 1'b0; rsp_ready[k] = 1'b0; last_addr[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_idle_zero(k, "reset");
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;

        for (int k = 0; k < 2; k++) begin
            do_req(k, 8'd5, 0, 0);
            do_req(k, 8'd7, 0, 0);
            do_req(k, 8'd200, 0, 0);
            do_req(k, 8'd127, 0, 0);
            do_req(k, 8'd128, 0, 0);
            do_req(k, 8'd5, 6, 0);
            do_req(k, 8'd3, 0, 10);
            do_req(k, 8'd4, 0, 0);
            rst_mid(k, 8'd5);
            do_req(k, 8'd5, 0, 0);
            for (int r = 0; r < 25; r++) begin
                logic [7:0] rid;
                if ($urandom_range(0, 3) == 0) rid = 8'($urandom_range(128, 255));
                else rid = 8'($urandom_range(0, 127));
                do_req(k, rid, $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
